// File: rtl/csr_commit_ctrl.sv
// WB-stage commit controller: CSR access, exception/ertn commit, GPR writeback, and IF redirect with a flush hold.
// Optional CSR_COMMIT_CNT_EN adds free-running exc_cnt/ertn_cnt commit counters.
module csr_commit_ctrl #(
  parameter int unsigned FLUSH_HOLD = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_to_ws_valid,
  output logic        ws_allow_in,
  input  logic [31:0] ms_pc,
  input  logic [31:0] ms_result,
  input  logic [4:0]  ms_dest,
  input  logic        ms_rf_we,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wdata,
  input  logic [31:0] ms_csr_mask,
  input  logic        ms_ertn,
  input  logic [4:0]  ms_exc_vec,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  output logic [31:0] csr_wmask,
  output logic        exc_signal,
  output logic        ertn_signal,
  output logic [5:0]  exc_ecode,
  output logic [8:0]  exc_esubcode,
  output logic [31:0] exc_pc,
  input  logic [31:0] csr_target_pc,
  input  logic        int_signal,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
`ifdef CSR_COMMIT_CNT_EN
  ,
  output logic [31:0] exc_cnt,
  output logic [31:0] ertn_cnt
`endif
);

  typedef enum logic [1:0] {RUN, REDIR, HOLD} state_t;

  localparam logic [3:0] HOLD_LOAD = (FLUSH_HOLD > 0) ? 4'(FLUSH_HOLD - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  hold_cnt;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [31:0] ws_result;
  logic [4:0]  ws_dest;
  logic        ws_rf_we;
  logic [1:0]  ws_csr_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_csr_wdata;
  logic [31:0] ws_csr_mask;
  logic        ws_ertn;
  logic [4:0]  ws_exc_vec;
  logic        exc, ert, commit, ws_load;

  // Interrupts are only taken against a live instruction in RUN.
  assign exc     = (state == RUN) && ws_valid && (int_signal || (|ws_exc_vec));
  assign ert     = (state == RUN) && ws_valid && ws_ertn && !exc;
  assign commit  = exc || ert;
  assign ws_load = ms_to_ws_valid && ws_allow_in && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid     <= 1'b0;
      ws_pc        <= '0;
      ws_result    <= '0;
      ws_dest      <= '0;
      ws_rf_we     <= 1'b0;
      ws_csr_op    <= '0;
      ws_csr_num   <= '0;
      ws_csr_wdata <= '0;
      ws_csr_mask  <= '0;
      ws_ertn      <= 1'b0;
      ws_exc_vec   <= '0;
    end else begin
      ws_valid <= ws_load;
      if (ws_load) begin
        ws_pc        <= ms_pc;
        ws_result    <= ms_result;
        ws_dest      <= ms_dest;
        ws_rf_we     <= ms_rf_we;
        ws_csr_op    <= ms_csr_op;
        ws_csr_num   <= ms_csr_num;
        ws_csr_wdata <= ms_csr_wdata;
        ws_csr_mask  <= ms_csr_mask;
        ws_ertn      <= ms_ertn;
        ws_exc_vec   <= ms_exc_vec;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RUN;
      hold_cnt    <= '0;
      redirect_pc <= '0;
    end else begin
      state <= state_nxt;
      if (commit)
        redirect_pc <= csr_target_pc;
      if (state == REDIR && redirect_ready)
        hold_cnt <= HOLD_LOAD;
      else if (state == HOLD && hold_cnt != 4'd0)
        hold_cnt <= hold_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (commit) state_nxt = REDIR;
      REDIR:   if (redirect_ready) state_nxt = (FLUSH_HOLD > 0) ? HOLD : RUN;
      HOLD:    if (hold_cnt == 4'd0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // resetn gating keeps ws_allow_in low while reset is asserted.
  always_comb begin
    redirect_valid = (state == REDIR);
    flush          = (state != RUN) || commit;
    ws_allow_in    = resetn && (state == RUN) && !commit;
  end

  always_comb begin
    exc_signal   = exc;
    ertn_signal  = ert;
    exc_pc       = ws_pc;
    exc_ecode    = 6'h00;
    exc_esubcode = 9'h000;
    if (exc && !int_signal) begin
      if      (ws_exc_vec[0]) exc_ecode = 6'h08;
      else if (ws_exc_vec[1]) exc_ecode = 6'h0D;
      else if (ws_exc_vec[2]) exc_ecode = 6'h0B;
      else if (ws_exc_vec[3]) exc_ecode = 6'h0C;
      else                    exc_ecode = 6'h09;
    end
  end

  always_comb begin
    csr_num   = ws_csr_num;
    csr_wdata = ws_csr_wdata;
    csr_we    = ws_valid && ws_csr_op[1] && !exc && (state == RUN);
    case (ws_csr_op)
      2'b10:   csr_wmask = '1;
      2'b11:   csr_wmask = ws_csr_mask;
      default: csr_wmask = '0;
    endcase
    rf_we    = ws_valid && ws_rf_we && !exc && (state == RUN);
    rf_waddr = ws_dest;
    rf_wdata = (ws_csr_op != 2'b00) ? csr_rdata : ws_result;
  end

`ifdef CSR_COMMIT_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_cnt  <= '0;
      ertn_cnt <= '0;
    end else begin
      if (exc_signal)  exc_cnt  <= exc_cnt + 32'd1;
      if (ertn_signal) ertn_cnt <= ertn_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Directed bench for csr_commit_ctrl (FLUSH_HOLD=2): CSR ops, exception priority, ertn, redirect handshake, async reset.
module tb_csr_commit_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allow_in;
  logic [31:0] ms_pc, ms_result, ms_csr_wdata, ms_csr_mask;
  logic [4:0]  ms_dest, ms_exc_vec;
  logic        ms_rf_we, ms_ertn;
  logic [1:0]  ms_csr_op;
  logic [13:0] ms_csr_num, csr_num;
  logic [31:0] csr_rdata, csr_wdata, csr_wmask, exc_pc, csr_target_pc, redirect_pc, rf_wdata;
  logic        csr_we, exc_signal, ertn_signal, int_signal, flush, redirect_valid, redirect_ready, rf_we;
  logic [5:0]  exc_ecode;
  logic [8:0]  exc_esubcode;
  logic [4:0]  rf_waddr;
`ifdef CSR_COMMIT_CNT_EN
  logic [31:0] exc_cnt, ertn_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csr_commit_ctrl #(.FLUSH_HOLD(2)) dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest), .ms_rf_we(ms_rf_we),
    .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num), .ms_csr_wdata(ms_csr_wdata),
    .ms_csr_mask(ms_csr_mask), .ms_ertn(ms_ertn), .ms_exc_vec(ms_exc_vec),
    .csr_num(csr_num), .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_wmask(csr_wmask), .exc_signal(exc_signal), .ertn_signal(ertn_signal),
    .exc_ecode(exc_ecode), .exc_esubcode(exc_esubcode), .exc_pc(exc_pc),
    .csr_target_pc(csr_target_pc), .int_signal(int_signal), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef CSR_COMMIT_CNT_EN
    , .exc_cnt(exc_cnt), .ertn_cnt(ertn_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction to WB; afterwards it sits in the stage register.
  task automatic load(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] wdata,
                      input logic [31:0] mask, input logic [31:0] result, input logic rfwe,
                      input logic ertn, input logic [4:0] vec);
    ms_csr_op = op; ms_pc = pc; ms_csr_wdata = wdata; ms_csr_mask = mask;
    ms_result = result; ms_rf_we = rfwe; ms_ertn = ertn; ms_exc_vec = vec;
    ms_to_ws_valid = 1'b1;
    step();
    ms_to_ws_valid = 1'b0;
  endtask

  // From the commit cycle: one REDIR cycle, handshake, two HOLD cycles, back in RUN.
  task automatic drain();
    step();
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    step();
    step();
  endtask

  logic [4:0] vec_tbl [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b11110};
  logic [5:0] code_tbl[6] = '{6'h08,    6'h0D,    6'h0B,    6'h0C,    6'h09,    6'h0D};

  initial begin
    resetn = 1'b0; ms_to_ws_valid = 1'b0; ms_pc = '0; ms_result = '0; ms_dest = 5'd5;
    ms_rf_we = 1'b0; ms_csr_op = 2'b00; ms_csr_num = 14'h30; ms_csr_wdata = '0; ms_csr_mask = '0;
    ms_ertn = 1'b0; ms_exc_vec = '0; csr_rdata = 32'hAA; csr_target_pc = '0;
    int_signal = 1'b0; redirect_ready = 1'b0;
    #1;
    chk("rst_allow_in", ws_allow_in, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redir_valid", redirect_valid, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_wmask", csr_wmask, 0);
    #11 resetn = 1'b1;
    step();
    chk("run_allow_in", ws_allow_in, 1);

    // csrwr
    load(2'b10, 32'h1c000000, 32'h1234, 32'h0, 32'h0, 1'b1, 1'b0, 5'b0);
    chk("wr_csr_we", csr_we, 1);
    chk("wr_csr_num", csr_num, 32'h30);
    chk("wr_wdata", csr_wdata, 32'h1234);
    chk("wr_wmask", csr_wmask, 32'hFFFFFFFF);
    chk("wr_rf_we", rf_we, 1);
    chk("wr_rf_waddr", rf_waddr, 5);
    chk("wr_rf_wdata", rf_wdata, 32'hAA);
    chk("wr_flush", flush, 0);
    chk("wr_exc", exc_signal, 0);

    // csrxchg
    csr_rdata = 32'h77;
    load(2'b11, 32'h1c000004, 32'h5555, 32'h0000FF00, 32'h0, 1'b1, 1'b0, 5'b0);
    chk("xchg_wmask", csr_wmask, 32'h0000FF00);
    chk("xchg_wdata", csr_wdata, 32'h5555);
    chk("xchg_rf_wdata", rf_wdata, 32'h77);
    chk("xchg_csr_we", csr_we, 1);

    // plain ALU writeback
    load(2'b00, 32'h1c000008, 32'h0, 32'h0, 32'hDEAD, 1'b1, 1'b0, 5'b0);
    chk("alu_rf_wdata", rf_wdata, 32'hDEAD);
    chk("alu_csr_we", csr_we, 0);
    chk("alu_wmask", csr_wmask, 0);

    // syscall with redirect held off for 3 cycles; ready in the commit cycle is ignored
    csr_target_pc = 32'h1c008000;
    load(2'b10, 32'h1c000100, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 5'b00100);
    redirect_ready = 1'b1;
    #1;
    chk("sys_exc", exc_signal, 1);
    chk("sys_ecode", exc_ecode, 6'h0B);
    chk("sys_esub", exc_esubcode, 0);
    chk("sys_exc_pc", exc_pc, 32'h1c000100);
    chk("sys_csr_we", csr_we, 0);
    chk("sys_rf_we", rf_we, 0);
    chk("sys_flush", flush, 1);
    chk("sys_allow_in", ws_allow_in, 0);
    step();
    redirect_ready = 1'b0;
    csr_target_pc = 32'hFFFF0000;
    for (int i = 0; i < 3; i++) begin
      chk("sys_redir_valid", redirect_valid, 1);
      chk("sys_redir_pc", redirect_pc, 32'h1c008000);
      chk("sys_exc_pulse", exc_signal, 0);
      if (i < 2) step();
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("sys_hold1_valid", redirect_valid, 0);
    chk("sys_hold1_flush", flush, 1);
    step();
    chk("sys_hold2_flush", flush, 1);
    step();
    chk("sys_run_flush", flush, 0);
    chk("sys_run_allow", ws_allow_in, 1);

    // interrupt beats ine on a csrwr; empty WB never takes it
    int_signal = 1'b1;
    load(2'b10, 32'h1c000200, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 5'b00010);
    chk("int_exc", exc_signal, 1);
    chk("int_ecode", exc_ecode, 0);
    chk("int_csr_we", csr_we, 0);
    drain();
    chk("int_empty_exc", exc_signal, 0);
    chk("int_empty_flush", flush, 0);
    int_signal = 1'b0;

    // ecode priority table
    for (int i = 0; i < 6; i++) begin
      load(2'b00, 32'h1c000300, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, vec_tbl[i]);
      chk($sformatf("prio_ecode_%0d", i), exc_ecode, code_tbl[i]);
      drain();
    end

    // ertn, with a csrwr waiting in MEM throughout the flush
    csr_target_pc = 32'h1c000204;
    load(2'b00, 32'h1c000400, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5'b0);
    ms_csr_op = 2'b10; ms_rf_we = 1'b0; ms_ertn = 1'b0; ms_to_ws_valid = 1'b1;
    chk("ertn_sig", ertn_signal, 1);
    chk("ertn_exc", exc_signal, 0);
    chk("ertn_flush", flush, 1);
    step();
    chk("ertn_pulse", ertn_signal, 0);
    chk("ertn_redir_pc", redirect_pc, 32'h1c000204);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("ertn_hold1_flush", flush, 1);
    chk("ertn_hold1_we", csr_we, 0);
    step();
    chk("ertn_hold2_flush", flush, 1);
    step();
    chk("ertn_run_flush", flush, 0);
    chk("ertn_ignored_we", csr_we, 0);
    step();
    ms_to_ws_valid = 1'b0;
    chk("ertn_after_we", csr_we, 1);
    step();

    // async reset while in REDIR
    csr_target_pc = 32'h1c008000;
    load(2'b00, 32'h1c000500, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'b00100);
    step();
    chk("arst_pre_valid", redirect_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", redirect_valid, 0);
    chk("arst_flush", flush, 0);
    chk("arst_redir_pc", redirect_pc, 0);
    #1 resetn = 1'b1;
    step();
    chk("arst_run_allow", ws_allow_in, 1);

`ifdef CSR_COMMIT_CNT_EN
    for (int i = 0; i < 3; i++) begin
      load(2'b00, 32'h1c000600, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'b01000);
      drain();
    end
    chk("cnt_exc", exc_cnt, 3);
    chk("cnt_ertn", ertn_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
